decode_stage: RTL and testbench

- Registered, handshaked successor to the combinational DECODER, for the pipelined core.
- Sits between fetch and execute. Decodes the same 16-bit ISA subset: ADD, AND, NOT, BR, JMP, LEA.
- Adds a per-register scoreboard that stalls RAW/WAW hazards until writeback, plus a flush input for taken branches/jumps.
- Exposes sign-extended immediates, the PC and a stall counter.

---
 rtl/decode_stage.sv | 171 +++++++++++++++++
 tb/tb_decode_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: registered, handshaked decode stage between fetch and execute.
// Decodes the ADD/AND/NOT/BR/JMP/LEA subset of the 16-bit ISA. A per-register
// scoreboard tracks issued but not yet retired register writes. Any RAW or WAW
// hazard against that scoreboard, or against the instruction held here, stalls
// fetch.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   fetch handshake; in_instr, in_pc carry the instruction
//   out_valid/out_ready execute handshake; out_* carry the decoded fields
//   wb_valid, wb_dr     execute retires a write to register wb_dr
//   flush               kill the held instruction (taken branch/jump)
//   stall_cycles        saturating count of hazard-stalled cycles
module decode_stage #(
   parameter int unsigned NUM_REGS    = 8,
   parameter int unsigned PC_W        = 16,
   parameter int unsigned BYPASS_WB   = 1,
   parameter int unsigned STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [15:0]            in_instr,
   input  logic [PC_W-1:0]        in_pc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [PC_W-1:0]        out_pc,
   output logic [1:0]             out_alu_op,
   output logic [1:0]             out_ssel,
   output logic                   out_we_reg,
   output logic                   out_branch,
   output logic [2:0]             out_nzp,
   output logic                   out_pc_ctrl_1,
   output logic [2:0]             out_sr1,
   output logic [2:0]             out_sr2,
   output logic [2:0]             out_dr,
   output logic [15:0]            out_imm,
   input  logic                   wb_valid,
   input  logic [2:0]             wb_dr,
   input  logic                   flush,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   // ---------------------------------------------------------------
   // Combinational decode of the offered instruction
   // ---------------------------------------------------------------
   logic [3:0]  op;
   logic        is_add, is_and, is_not, is_br, is_jmp, is_lea;
   logic        d_we, d_use_sr1, d_use_sr2;
   logic [1:0]  d_ssel;
   logic [15:0] d_imm;

   always_comb begin
      op     = in_instr[15:12];
      is_add = (op == 4'b0001);
      is_and = (op == 4'b0101);
      is_not = (op == 4'b1001);
      is_br  = (op == 4'b0000);
      is_jmp = (op == 4'b1100);
      is_lea = (op == 4'b1110);

      // (op==1110)|(op[1:0]==01), narrowed to known opcodes so the reserved
      // 1101 encoding does not write a register.
      d_we      = is_add | is_and | is_not | is_lea;
      d_use_sr1 = is_add | is_and | is_not | is_jmp;
      d_use_sr2 = (is_add | is_and) & ~in_instr[5];

      if (in_instr[5] && (op[1:0] == 2'b01))
         d_ssel = 2'b00;
      else if (is_lea)
         d_ssel = 2'b01;
      else
         d_ssel = 2'b10;

      if (d_ssel == 2'b00)
         d_imm = {{11{in_instr[4]}}, in_instr[4:0]};
      else
         d_imm = {{7{in_instr[8]}}, in_instr[8:0]};
   end

   // ---------------------------------------------------------------
   // Scoreboard and hazard detection
   // ---------------------------------------------------------------
   logic [NUM_REGS-1:0] scoreboard;
   logic [NUM_REGS-1:0] wb_mask;
   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] sb_eff;
   logic [7:0]          reg_busy;
   logic                issue;
   logic                br_busy;
   logic                hazard;

   assign issue = out_valid & out_ready & ~flush;

   always_comb begin
      wb_mask  = '0;
      set_mask = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         wb_mask[i]  = wb_valid & (wb_dr == 3'(i));
         set_mask[i] = issue & out_we_reg & (out_dr == 3'(i));
      end
   end

   // With bypass, a same-cycle writeback already hides the pending bit.
   assign sb_eff = (BYPASS_WB != 0) ? (scoreboard & ~wb_mask) : scoreboard;

   always_comb begin
      reg_busy = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++)
         reg_busy[i] = sb_eff[i] | (out_valid & out_we_reg & (out_dr == 3'(i)));
   end

   // BR reads only condition codes, which any outstanding write may change.
   assign br_busy = (|sb_eff) | (out_valid & out_we_reg);

   assign hazard = (d_use_sr1 & reg_busy[in_instr[8:6]])
                 | (d_use_sr2 & reg_busy[in_instr[2:0]])
                 | (d_we      & reg_busy[in_instr[11:9]])
                 | (is_br     & br_busy);

   assign in_ready = (~out_valid | out_ready) & ~hazard & ~flush;

   // ---------------------------------------------------------------
   // Sequential state
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid     <= 1'b0;
         out_pc        <= '0;
         out_alu_op    <= '0;
         out_ssel      <= '0;
         out_we_reg    <= 1'b0;
         out_branch    <= 1'b0;
         out_nzp       <= '0;
         out_pc_ctrl_1 <= 1'b0;
         out_sr1       <= '0;
         out_sr2       <= '0;
         out_dr        <= '0;
         out_imm       <= '0;
         scoreboard    <= '0;
         stall_cycles  <= '0;
      end else begin
         if (flush) begin
            out_valid <= 1'b0;
         end else if (in_valid && in_ready) begin
            out_valid     <= 1'b1;
            out_pc        <= in_pc;
            out_alu_op    <= in_instr[15:14];
            out_ssel      <= d_ssel;
            out_we_reg    <= d_we;
            out_branch    <= is_br;
            out_nzp       <= in_instr[11:9];
            out_pc_ctrl_1 <= is_jmp;
            out_sr1       <= in_instr[8:6];
            out_sr2       <= in_instr[2:0];
            out_dr        <= in_instr[11:9];
            out_imm       <= d_imm;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         // Set after clear so an issue wins over a same-register writeback.
         scoreboard <= (scoreboard & ~wb_mask) | set_mask;

         if (in_valid && hazard && !flush && (stall_cycles != '1))
            stall_cycles <= stall_cycles + STALL_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-computed expectations for decode
// fields, hazard stalls, bypassed writeback, flush and reset. A second
// instance with a 2-bit stall counter shares all inputs to show saturation.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst, in_valid, out_ready, wb_valid, flush;
   logic [15:0] in_instr, in_pc;
   logic [2:0]  wb_dr;

   logic        in_ready, out_valid, out_we_reg, out_branch, out_pc_ctrl_1;
   logic [15:0] out_pc, out_imm, stall_cycles;
   logic [1:0]  out_alu_op, out_ssel;
   logic [2:0]  out_nzp, out_sr1, out_sr2, out_dr;

   logic        b_in_ready, b_out_valid, b_we_reg, b_branch, b_pc_ctrl_1;
   logic [15:0] b_pc, b_imm;
   logic [1:0]  b_alu_op, b_ssel, b_stall;
   logic [2:0]  b_nzp, b_sr1, b_sr2, b_dr;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   decode_stage #(.NUM_REGS(8), .PC_W(16), .BYPASS_WB(1), .STALL_CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_alu_op(out_alu_op),
      .out_ssel(out_ssel), .out_we_reg(out_we_reg), .out_branch(out_branch),
      .out_nzp(out_nzp), .out_pc_ctrl_1(out_pc_ctrl_1), .out_sr1(out_sr1),
      .out_sr2(out_sr2), .out_dr(out_dr), .out_imm(out_imm),
      .wb_valid(wb_valid), .wb_dr(wb_dr), .flush(flush),
      .stall_cycles(stall_cycles)
   );

   decode_stage #(.NUM_REGS(8), .PC_W(16), .BYPASS_WB(1), .STALL_CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_out_valid),
      .out_ready(out_ready), .out_pc(b_pc), .out_alu_op(b_alu_op),
      .out_ssel(b_ssel), .out_we_reg(b_we_reg), .out_branch(b_branch),
      .out_nzp(b_nzp), .out_pc_ctrl_1(b_pc_ctrl_1), .out_sr1(b_sr1),
      .out_sr2(b_sr2), .out_dr(b_dr), .out_imm(b_imm),
      .wb_valid(wb_valid), .wb_dr(wb_dr), .flush(flush),
      .stall_cycles(b_stall)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
      out_ready = 1'b0; wb_valid = 1'b0; wb_dr = '0; flush = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst_bundle", {out_valid, out_pc, out_alu_op, out_ssel, out_we_reg,
                         out_branch, out_nzp, out_pc_ctrl_1, out_sr1, out_sr2,
                         out_dr, out_imm}, 64'd0);
      chk("rst_stall", stall_cycles, 0);

      // ADD R1,R2,R3
      rst = 1'b0; in_valid = 1'b1; in_instr = 16'h1283; in_pc = 16'h3000; out_ready = 1'b1;
      #1 chk("add_rdy", in_ready, 1);
      tick();
      chk("add_valid", out_valid, 1);
      chk("add_pc", out_pc, 16'h3000);
      chk("add_dr", out_dr, 1);
      chk("add_sr1", out_sr1, 2);
      chk("add_sr2", out_sr2, 3);
      chk("add_ssel", out_ssel, 2'b10);
      chk("add_we", out_we_reg, 1);
      chk("add_alu", out_alu_op, 0);
      chk("add_imm", out_imm, 16'h0083);
      in_valid = 1'b0;
      tick();
      chk("add_issued", out_valid, 0);

      // ADD R4,R1,#1 waits on pending R1
      in_valid = 1'b1; in_instr = 16'h1861; in_pc = 16'h3001;
      #1 chk("raw_rdy", in_ready, 0);
      repeat (3) tick();
      chk("raw_stall", stall_cycles, 3);
      chk("sat_stall3", b_stall, 3);
      wb_valid = 1'b1; wb_dr = 3'd1;
      #1 chk("bypass_rdy", in_ready, 1);
      tick();
      wb_valid = 1'b0;
      chk("imm_valid", out_valid, 1);
      chk("imm_val", out_imm, 16'h0001);
      chk("imm_ssel", out_ssel, 2'b00);
      chk("imm_dr", out_dr, 4);
      chk("imm_sr1", out_sr1, 1);
      chk("imm_stall", stall_cycles, 3);

      // LEA R2,#-1
      in_instr = 16'hE5FF; in_pc = 16'h3002;
      #1 chk("lea_rdy", in_ready, 1);
      tick();
      chk("lea_ssel", out_ssel, 2'b01);
      chk("lea_imm", out_imm, 16'hFFFF);
      chk("lea_we", out_we_reg, 1);
      chk("lea_dr", out_dr, 2);

      // NOT R5,R6
      in_instr = 16'h9BBF; in_pc = 16'h3003;
      #1 chk("not_rdy", in_ready, 1);
      tick();
      chk("not_alu", out_alu_op, 2'b10);
      chk("not_dr", out_dr, 5);
      chk("not_sr1", out_sr1, 6);
      chk("not_we", out_we_reg, 1);
      in_valid = 1'b0;
      tick();

      // WAW: ADD R5,R0,#-1 while R5 pending
      in_valid = 1'b1; in_instr = 16'h1A3F;
      #1 chk("waw_rdy", in_ready, 0);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         wb_valid = 1'b1;
         wb_dr = (i == 0) ? 3'd4 : (i == 1) ? 3'd2 : 3'd5;
         tick();
      end
      wb_valid = 1'b0;

      // BRnzp behind ADD R1: held-instruction then scoreboard stall
      in_valid = 1'b1; in_instr = 16'h1283; in_pc = 16'h3010;
      #1 chk("br_pre_rdy", in_ready, 1);
      tick();
      in_instr = 16'h0E05; in_pc = 16'h3011;
      #1 chk("br_held_rdy", in_ready, 0);
      tick();
      chk("br_sb_rdy", in_ready, 0);
      tick();
      chk("br_stall", stall_cycles, 5);
      chk("sat_hold", b_stall, 3);
      wb_valid = 1'b1; wb_dr = 3'd1;
      #1 chk("br_wb_rdy", in_ready, 1);
      tick();
      wb_valid = 1'b0;
      chk("br_valid", out_valid, 1);
      chk("br_branch", out_branch, 1);
      chk("br_nzp", out_nzp, 3'b111);
      chk("br_imm", out_imm, 16'h0005);
      chk("br_we", out_we_reg, 0);
      in_valid = 1'b0;
      tick();

      // JMP R3 held, then flushed
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'hC0C0; in_pc = 16'h3020;
      #1 chk("jmp_rdy", in_ready, 1);
      tick();
      chk("jmp_valid", out_valid, 1);
      chk("jmp_ctrl", out_pc_ctrl_1, 1);
      chk("jmp_sr1", out_sr1, 3);
      chk("jmp_we", out_we_reg, 0);
      in_valid = 1'b0;
      tick();
      chk("jmp_hold_valid", out_valid, 1);
      chk("jmp_hold_pc", out_pc, 16'h3020);
      flush = 1'b1; in_valid = 1'b1; in_instr = 16'h1283; in_pc = 16'h3021;
      #1 chk("flush_rdy", in_ready, 0);
      tick();
      flush = 1'b0;
      chk("flush_valid", out_valid, 0);

      // Flushed ADD R1 must not mark R1 pending
      #1 chk("add2_rdy", in_ready, 1);
      tick();
      chk("add2_valid", out_valid, 1);
      chk("add2_dr", out_dr, 1);
      flush = 1'b1; out_ready = 1'b1; in_instr = 16'h1861; in_pc = 16'h3022;
      tick();
      flush = 1'b0;
      chk("flush2_valid", out_valid, 0);
      chk("flush2_stall", stall_cycles, 5);
      #1 chk("flush2_nosb", in_ready, 1);
      tick();
      chk("flush2_dr", out_dr, 4);
      in_valid = 1'b0;
      tick();
      wb_valid = 1'b1; wb_dr = 3'd4;
      tick();
      wb_valid = 1'b0;

      // Build scoreboard = 0x06 with NOT held, then reset
      in_valid = 1'b1; in_instr = 16'h1283; in_pc = 16'h3030;
      tick();
      in_instr = 16'hE5FF; in_pc = 16'h3031;
      tick();
      in_instr = 16'h9BBF; in_pc = 16'h3032;
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      chk("pre_rst_valid", out_valid, 1);
      chk("pre_rst_dr", out_dr, 5);
      in_valid = 1'b1; in_instr = 16'h0E05; in_pc = 16'h3033;
      #1 chk("pre_rst_br_rdy", in_ready, 0);
      rst = 1'b1;
      tick();
      chk("rst2_bundle", {out_valid, out_pc, out_alu_op, out_ssel, out_we_reg,
                          out_branch, out_nzp, out_pc_ctrl_1, out_sr1, out_sr2,
                          out_dr, out_imm}, 64'd0);
      chk("rst2_stall", stall_cycles, 0);
      chk("rst2_sat_bundle", {b_out_valid, b_pc, b_alu_op, b_ssel, b_we_reg,
                              b_branch, b_nzp, b_pc_ctrl_1, b_sr1, b_sr2,
                              b_dr, b_imm}, 64'd0);
      chk("rst2_sat_stall", b_stall, 0);
      rst = 1'b0; out_ready = 1'b1;
      #1 chk("rst2_br_rdy", in_ready, 1);
      chk("rst2_sat_rdy", b_in_ready, 1);
      tick();
      chk("rst2_br_valid", out_valid, 1);
      chk("rst2_br_branch", out_branch, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got=running exp=finished");
      $fatal(1);
   end

endmodule
